// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: EX-stage forwarding, load-use stall, taken-branch flush
// and a per-register scoreboard for the variable-latency long-op (mul/div) unit.
// Optional feature macro: LONG_BYPASS_EN. When it is defined, a register whose long
// result lands this cycle no longer blocks D, and a full pending counter accepts a
// new long op in the same cycle that one completes.
module hazard_scoreboard_unit #(
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int MAX_PEND = 4,
    parameter int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] Rs1D,
    input  logic [AW-1:0] Rs2D,
    input  logic [AW-1:0] RdD,
    input  logic          UsesRs1D,
    input  logic          UsesRs2D,
    input  logic          RegWriteD,
    input  logic          LongOpD,
    input  logic [AW-1:0] Rs1E,
    input  logic [AW-1:0] Rs2E,
    input  logic [AW-1:0] RdE,
    input  logic          LoadE,
    input  logic          PCSrcE,
    input  logic          RegWriteM,
    input  logic [AW-1:0] RdM,
    input  logic          RegWriteW,
    input  logic [AW-1:0] RdW,
    input  logic          LongDone,
    input  logic [AW-1:0] LongRd,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushD,
    output logic          FlushE,
    output logic          LongIssue,
    output logic [CW-1:0] PendCnt,
    output logic          SbErr
);

    // Hit vector spans the full address space so any AW-bit index is in range;
    // entries at or above NREGS never hit.
    localparam int            NA   = 1 << AW;
    localparam logic [CW-1:0] FULL = CW'(MAX_PEND);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_v;
    logic [NREGS-1:0] clr_v;
    logic [NA-1:0]    hitv;
    logic             lw_stall;
    logic             full_stall;
    logic             sb_stall;
    logic             stall;
    logic             err_underflow;
    logic             err_not_busy;

    // Operand forwarding: M result has priority over W; x0 is never forwarded.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != '0 && RdM == Rs1E)      ForwardAE = 2'b10;
        else if (RegWriteW && RdW != '0 && RdW == Rs1E) ForwardAE = 2'b01;
        if (RegWriteM && RdM != '0 && RdM == Rs2E)      ForwardBE = 2'b10;
        else if (RegWriteW && RdW != '0 && RdW == Rs2E) ForwardBE = 2'b01;
    end

    // Per-register scoreboard hit; with bypass, a completing result is not a hazard.
    always_comb begin
        hitv = '0;
        for (int r = 1; r < NREGS; r++) begin
            hitv[r] = busy[r];
`ifdef LONG_BYPASS_EN
            if (LongDone && LongRd == AW'(r)) hitv[r] = 1'b0;
`endif
        end
    end

    // Stall and flush generation; a taken branch kills D, so it also blocks issue.
    always_comb begin
        lw_stall = LoadE && RdE != '0 &&
                   ((UsesRs1D && RdE == Rs1D) || (UsesRs2D && RdE == Rs2D));
`ifdef LONG_BYPASS_EN
        full_stall = LongOpD && PendCnt == FULL && !LongDone;
`else
        full_stall = LongOpD && PendCnt == FULL;
`endif
        sb_stall = (UsesRs1D && hitv[Rs1D]) ||
                   (UsesRs2D && hitv[Rs2D]) ||
                   (RegWriteD && RdD != '0 && hitv[RdD]) ||
                   full_stall;
        stall     = lw_stall || sb_stall;
        StallF    = stall;
        StallD    = stall;
        FlushD    = PCSrcE;
        FlushE    = stall || PCSrcE;
        LongIssue = LongOpD && !StallD && !FlushE;
    end

    // Per-register set/clear requests and protocol error detection for this cycle.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int r = 1; r < NREGS; r++) begin
            set_v[r] = LongIssue && RdD == AW'(r);
            clr_v[r] = LongDone && LongRd == AW'(r);
        end
        err_underflow = LongDone && PendCnt == '0 && !LongIssue;
        err_not_busy  = LongDone && LongRd != '0 && !(|(busy & clr_v));
    end

    // Scoreboard state: set wins over clear, counter saturates at zero on underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            PendCnt <= '0;
            SbErr   <= 1'b0;
        end else begin
            busy <= ((busy & ~clr_v) | set_v) & ~NREGS'(1);
            if (LongIssue && !LongDone)
                PendCnt <= PendCnt + CW'(1);
            else if (!LongIssue && LongDone && PendCnt != '0)
                PendCnt <= PendCnt - CW'(1);
            if (err_underflow || err_not_busy)
                SbErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed test-plan sequences followed by random traffic.
// Expected outputs are queued when stimulus is applied and checked by a separate
// monitor on the falling edge.
module tb_hazard_scoreboard_unit;

    localparam int NREGS    = 32;
    localparam int AW       = 5;
    localparam int MAX_PEND = 4;
    localparam int CW       = $clog2(MAX_PEND + 1);
`ifdef LONG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongRd;
    logic          UsesRs1D, UsesRs2D, RegWriteD, LongOpD, LoadE, PCSrcE;
    logic          RegWriteM, RegWriteW, LongDone;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, FlushD, FlushE, LongIssue, SbErr;
    logic [CW-1:0] PendCnt;

    hazard_scoreboard_unit #(.NREGS(NREGS), .AW(AW), .MAX_PEND(MAX_PEND)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D), .RegWriteD(RegWriteD), .LongOpD(LongOpD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
        .LongDone(LongDone), .LongRd(LongRd),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .LongIssue(LongIssue), .PendCnt(PendCnt), .SbErr(SbErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fa, fb, sf, sd, fd, fe, li, pc, err;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: set of busy registers, in-flight count, sticky error.
    bit   mbusy[NREGS];
    int   mpend;
    bit   merr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every falling edge with a pending expectation compares all outputs.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("ForwardAE", int'(ForwardAE), e.fa);
            chk("ForwardBE", int'(ForwardBE), e.fb);
            chk("StallF",    int'(StallF),    e.sf);
            chk("StallD",    int'(StallD),    e.sd);
            chk("FlushD",    int'(FlushD),    e.fd);
            chk("FlushE",    int'(FlushE),    e.fe);
            chk("LongIssue", int'(LongIssue), e.li);
            chk("PendCnt",   int'(PendCnt),   e.pc);
            chk("SbErr",     int'(SbErr),     e.err);
        end
    end

    function automatic int mfwd(input int rs);
        if (RegWriteM && RdM != 0 && int'(RdM) == rs) return 2;
        if (RegWriteW && RdW != 0 && int'(RdW) == rs) return 1;
        return 0;
    endfunction

    function automatic bit mhit(input int r);
        if (r == 0 || r >= NREGS) return 1'b0;
        if (!mbusy[r]) return 1'b0;
        if (BYP && LongDone && int'(LongRd) == r) return 1'b0;
        return 1'b1;
    endfunction

    // Compute expected outputs for the applied inputs, optionally queue them,
    // advance the reference state, then move to just after the next rising edge.
    task automatic step(input bit push);
        exp_t e;
        bit   lw, sb, st, iss;
        int   ld;
        lw = LoadE && RdE != 0 &&
             ((UsesRs1D && RdE == Rs1D) || (UsesRs2D && RdE == Rs2D));
        sb = (UsesRs1D && mhit(int'(Rs1D))) || (UsesRs2D && mhit(int'(Rs2D))) ||
             (RegWriteD && RdD != 0 && mhit(int'(RdD))) ||
             (LongOpD && mpend == MAX_PEND && !(BYP && LongDone));
        st  = lw || sb;
        iss = LongOpD && !st && !PCSrcE;
        e.fa = mfwd(int'(Rs1E)); e.fb = mfwd(int'(Rs2E));
        e.sf = int'(st); e.sd = int'(st); e.fd = int'(PCSrcE);
        e.fe = int'(st || PCSrcE); e.li = int'(iss);
        e.pc = mpend; e.err = int'(merr);
        if (push) expq.push_back(e);
        if (rst) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            mpend = 0;
            merr  = 1'b0;
        end else begin
            ld = int'(LongRd);
            if (LongDone && mpend == 0 && !iss) merr = 1'b1;
            if (LongDone && ld != 0 && !(ld < NREGS && mbusy[ld])) merr = 1'b1;
            if (LongDone && ld != 0 && ld < NREGS) mbusy[ld] = 1'b0;
            if (iss && RdD != 0 && int'(RdD) < NREGS) mbusy[int'(RdD)] = 1'b1;
            if (iss && !LongDone) mpend++;
            else if (!iss && LongDone && mpend > 0) mpend--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rst = 1'b0;
        Rs1D = '0; Rs2D = '0; RdD = '0; UsesRs1D = 0; UsesRs2D = 0; RegWriteD = 0; LongOpD = 0;
        Rs1E = '0; Rs2E = '0; RdE = '0; LoadE = 0; PCSrcE = 0;
        RegWriteM = 0; RdM = '0; RegWriteW = 0; RdW = '0; LongDone = 0; LongRd = '0;
    endtask

    function automatic logic [AW-1:0] rreg();
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic rand_in();
        int busyl[$];
        Rs1D = rreg(); Rs2D = rreg(); RdD = rreg();
        UsesRs1D = 1'($urandom_range(0, 1)); UsesRs2D = 1'($urandom_range(0, 1));
        RegWriteD = 1'($urandom_range(0, 1));
        LongOpD = ($urandom_range(0, 2) == 0);
        Rs1E = rreg(); Rs2E = rreg(); RdE = rreg();
        LoadE = ($urandom_range(0, 3) == 0);
        PCSrcE = ($urandom_range(0, 7) == 0);
        RegWriteM = 1'($urandom_range(0, 1)); RdM = rreg();
        RegWriteW = 1'($urandom_range(0, 1)); RdW = rreg();
        rst = ($urandom_range(0, 249) == 0);
        LongDone = 1'b0; LongRd = '0;
        if (mpend > 0 && $urandom_range(0, 2) == 0) begin
            LongDone = 1'b1;
            for (int i = 1; i < NREGS; i++) if (mbusy[i]) busyl.push_back(i);
            if (busyl.size() > 0) LongRd = AW'(busyl[$urandom_range(0, busyl.size() - 1)]);
        end
        if ($urandom_range(0, 299) == 0) begin
            LongDone = 1'b1;
            LongRd = AW'($urandom_range(0, NREGS - 1));
        end
    endtask

    initial begin
        mpend = 0; merr = 1'b0;
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        clr_in();
        rst = 1'b1;
        step(1'b0);                       // flush unknown power-up state
        step(1'b1);                       // reset-state check
        clr_in();

        // Forwarding priority
        Rs1E = 5; RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; step(1'b1);
        RdM = 0; step(1'b1);
        RegWriteW = 0; step(1'b1);
        clr_in();

        // Load-use stall and its x0 exemption
        LoadE = 1; RdE = 7; UsesRs2D = 1; Rs2D = 7; step(1'b1);
        RdE = 0; step(1'b1);
        clr_in();

        // RAW on a long-op destination until completion
        LongOpD = 1; RegWriteD = 1; RdD = 9; step(1'b1);
        clr_in(); UsesRs1D = 1; Rs1D = 9; step(1'b1); step(1'b1);
        LongDone = 1; LongRd = 9; step(1'b1);
        LongDone = 0; step(1'b1); step(1'b1);
        clr_in();

        // Pending-counter limit
        for (int r = 1; r <= 4; r++) begin
            LongOpD = 1; RegWriteD = 1; RdD = AW'(r); step(1'b1);
        end
        RdD = 5; step(1'b1); step(1'b1);
        LongDone = 1; LongRd = 1; step(1'b1);
        LongDone = 0; step(1'b1);
        LongOpD = 0; RegWriteD = 0;
        for (int r = 2; r <= 5; r++) begin
            LongDone = 1; LongRd = AW'(r); step(1'b1);
        end
        clr_in(); step(1'b1);

        // Taken branch blocks issue
        LongOpD = 1; RegWriteD = 1; RdD = 6; PCSrcE = 1; step(1'b1);
        clr_in(); step(1'b1);

        // Underflow error is sticky; reset clears pending state and error
        LongDone = 1; LongRd = 0; step(1'b1);
        LongDone = 0; step(1'b1); step(1'b1);
        LongOpD = 1; RegWriteD = 1; RdD = 10; step(1'b1);
        RdD = 11; step(1'b1);
        clr_in(); rst = 1; step(1'b1);
        rst = 0; UsesRs1D = 1; Rs1D = 10; step(1'b1);
        clr_in(); LongDone = 1; LongRd = 10; step(1'b1);
        clr_in(); step(1'b1);
        rst = 1; step(1'b1);
        clr_in();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rand_in();
            step(1'b1);
        end
        clr_in();

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
